// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - 8-digit multiplexed 7-segment driver for the alarm clock board.
// Digits 0-3 show current time, 4-7 the alarm time; outputs are registered with 1-cycle latency.
module seg7_scan_driver #(
  parameter int SCAN_DIV    = 100000,
  parameter int GUARD_CYC   = 16,
  parameter int BLINK_TICKS = 250,
  parameter int LZB         = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] minone_now,
  input  logic [3:0] mindec_now,
  input  logic [3:0] hourone_now,
  input  logic [3:0] hourdec_now,
  input  logic [3:0] minone_bud,
  input  logic [3:0] mindec_bud,
  input  logic [3:0] hourone_bud,
  input  logic [3:0] hourdec_bud,
  input  logic       bud_en,
  input  logic       bud_state,
  input  logic [7:0] blink_mask,
  output logic       CA,
  output logic       CB,
  output logic       CC,
  output logic       CD,
  output logic       CE,
  output logic       CF,
  output logic       CG,
  output logic       DP,
  output logic [7:0] AN
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [PW-1:0] PCNT_LAST = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] GUARD_END = PW'(GUARD_CYC);
  localparam logic [BW-1:0] BCNT_LAST = BW'(BLINK_TICKS - 1);

  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          bph_q, bph_d;
  logic [7:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;

  logic       tick;
  logic [3:0] cur_val;
  logic [6:0] cur_seg;
  logic       blank;

  always_comb begin
    cur_val = 4'd0;
    case (idx_q)
      3'd0: cur_val = minone_now;
      3'd1: cur_val = mindec_now;
      3'd2: cur_val = hourone_now;
      3'd3: cur_val = hourdec_now;
      3'd4: cur_val = minone_bud;
      3'd5: cur_val = mindec_bud;
      3'd6: cur_val = hourone_bud;
      default: cur_val = hourdec_bud;
    endcase
  end

  // {CG,CF,CE,CD,CC,CB,CA}; non-BCD values stay dark rather than showing garbage
  always_comb begin
    cur_seg = 7'h7F;
    case (cur_val)
      4'd0: cur_seg = 7'h40;
      4'd1: cur_seg = 7'h79;
      4'd2: cur_seg = 7'h24;
      4'd3: cur_seg = 7'h30;
      4'd4: cur_seg = 7'h19;
      4'd5: cur_seg = 7'h12;
      4'd6: cur_seg = 7'h02;
      4'd7: cur_seg = 7'h78;
      4'd8: cur_seg = 7'h00;
      4'd9: cur_seg = 7'h10;
      default: cur_seg = 7'h7F;
    endcase
  end

  always_comb begin
    tick   = (pcnt_q == PCNT_LAST);
    pcnt_d = tick ? '0 : pcnt_q + 1'b1;
    idx_d  = tick ? idx_q + 3'd1 : idx_q;
    bcnt_d = bcnt_q;
    bph_d  = bph_q;
    if (tick) begin
      if (bcnt_q == BCNT_LAST) begin
        bcnt_d = '0;
        bph_d  = ~bph_q;
      end else begin
        bcnt_d = bcnt_q + 1'b1;
      end
    end

    blank = (pcnt_q < GUARD_END)
         || (idx_q[2] && !bud_en)
         || (bph_q && blink_mask[idx_q])
         || (bph_q && bud_state && !idx_q[2])
         || ((LZB == 1) && (idx_q[1:0] == 2'd3) && (cur_val == 4'd0));

    an_d  = 8'hFF;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    if (!blank) begin
      an_d  = ~(8'h01 << idx_q);
      seg_d = cur_seg;
      dp_d  = !((idx_q == 3'd2) && !bph_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt_q <= '0;
      idx_q  <= 3'd0;
      bcnt_q <= '0;
      bph_q  <= 1'b0;
      an_q   <= 8'hFF;
      seg_q  <= 7'h7F;
      dp_q   <= 1'b1;
    end else begin
      pcnt_q <= pcnt_d;
      idx_q  <= idx_d;
      bcnt_q <= bcnt_d;
      bph_q  <= bph_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
    end
  end

  assign {CG, CF, CE, CD, CC, CB, CA} = seg_q;
  assign DP = dp_q;
  assign AN = an_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - scoreboard bench for seg7_scan_driver.
// Expected outputs come from a cycle-count model and are compared one cycle later.
module tb_seg7_scan_driver;

  localparam int S = 8;
  localparam int G = 2;
  localparam int B = 2;
  localparam int L = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] minone_now, mindec_now, hourone_now, hourdec_now;
  logic [3:0] minone_bud, mindec_bud, hourone_bud, hourdec_bud;
  logic       bud_en, bud_state;
  logic [7:0] blink_mask;
  logic       CA, CB, CC, CD, CE, CF, CG, DP;
  logic [7:0] AN;

  seg7_scan_driver #(
    .SCAN_DIV(S), .GUARD_CYC(G), .BLINK_TICKS(B), .LZB(L)
  ) dut (
    .clk(clk), .rst(rst),
    .minone_now(minone_now), .mindec_now(mindec_now),
    .hourone_now(hourone_now), .hourdec_now(hourdec_now),
    .minone_bud(minone_bud), .mindec_bud(mindec_bud),
    .hourone_bud(hourone_bud), .hourdec_bud(hourdec_bud),
    .bud_en(bud_en), .bud_state(bud_state), .blink_mask(blink_mask),
    .CA(CA), .CB(CB), .CC(CC), .CD(CD), .CE(CE), .CF(CF), .CG(CG),
    .DP(DP), .AN(AN)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          t_m   = 0;
  logic [15:0] exp_q[$];
  logic [7:0]  lit_an[$];
  logic [6:0]  lit_seg[$];
  logic [7:0]  prev_an = 8'hFF;
  bit          rec = 0;
  bit          chk_int = 0;
  logic [6:0]  seg_obs;
  logic [7:0]  an_tab[8];
  logic [6:0]  seg_tab[8];

  assign seg_obs = {CG, CF, CE, CD, CC, CB, CA};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, got, exp, t_m);
    end
  endtask

  function automatic logic [3:0] digit(input int ix);
    case (ix)
      0: return minone_now;
      1: return mindec_now;
      2: return hourone_now;
      3: return hourdec_now;
      4: return minone_bud;
      5: return mindec_bud;
      6: return hourone_bud;
      default: return hourdec_bud;
    endcase
  endfunction

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    case (v)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  // Counter state expressed as plain arithmetic on cycles since reset.
  function automatic logic [15:0] model();
    int pc, ix, ph;
    logic [3:0] v;
    bit blank;
    if (rst) return {8'hFF, 7'h7F, 1'b1};
    pc = t_m % S;
    ix = (t_m / S) % 8;
    ph = (t_m / (S * B)) % 2;
    v  = digit(ix);
    blank = (pc < G) || (ix >= 4 && !bud_en) || (ph == 1 && blink_mask[ix])
         || (ph == 1 && bud_state && ix <= 3)
         || (L == 1 && (ix == 3 || ix == 7) && v == 4'd0);
    if (blank) return {8'hFF, 7'h7F, 1'b1};
    return {~(8'h01 << ix), seg_of(v), !(ix == 2 && ph == 0)};
  endfunction

  task automatic cycle();
    logic [15:0] e;
    exp_q.push_back(model());
    t_m = rst ? 0 : t_m + 1;
    @(posedge clk);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      check("queue_empty", 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      check("an", 32'(AN), 32'(e[15:8]));
      check("seg", 32'(seg_obs), 32'(e[7:1]));
      check("dp", 32'(DP), 32'(e[0]));
    end
    if (chk_int) begin
      check("idx", 32'(dut.idx_q), 32'((t_m / S) % 8));
      check("bph", 32'(dut.bph_q), 32'((t_m / (S * B)) % 2));
    end
    if (rec && AN !== 8'hFF && prev_an === 8'hFF) begin
      lit_an.push_back(AN);
      lit_seg.push_back(seg_obs);
    end
    prev_an = AN;
  endtask

  task automatic run_until(input int slot, input int pc);
    for (int k = 0; k < 2 * S * 8; k++) begin
      if ((t_m / S) % 8 == slot && t_m % S == pc) return;
      cycle();
    end
    check("run_until_timeout", 32'(t_m), 32'(slot * S + pc));
  endtask

  initial begin
    an_tab  = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
    seg_tab = '{7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00};
    minone_now = 4'd1; mindec_now = 4'd2; hourone_now = 4'd3; hourdec_now = 4'd4;
    minone_bud = 4'd5; mindec_bud = 4'd6; hourone_bud = 4'd7; hourdec_bud = 4'd8;
    bud_en = 1'b1; bud_state = 1'b0; blink_mask = 8'h00;

    rst = 1'b1;
    repeat (3) cycle();
    rst = 1'b0;
    rec = 1;
    repeat (70) cycle();
    rec = 0;
    check("lit_count", 32'(lit_an.size() >= 8), 32'd1);
    for (int k = 0; k < 8; k++) begin
      if (k < lit_an.size()) begin
        check("slot_an", 32'(lit_an[k]), 32'(an_tab[k]));
        check("slot_seg", 32'(lit_seg[k]), 32'(seg_tab[k]));
      end
    end

    hourdec_now = 4'd0; hourdec_bud = 4'd0;
    repeat (64) cycle();

    hourdec_now = 4'd4; hourdec_bud = 4'd8;
    bud_en = 1'b0;
    repeat (64) cycle();
    run_until(5, 4);
    bud_en = 1'b1;
    cycle();
    check("bud_en_mid", 32'(AN), 32'hDF);

    bud_state = 1'b1;
    repeat (128) cycle();
    bud_state = 1'b0;

    minone_now = 4'hC;
    repeat (64) cycle();
    run_until(3, 5);
    rst = 1'b1;
    cycle();
    check("rst_an", 32'(AN), 32'hFF);
    rst = 1'b0;
    cycle();
    check("guard0_an", 32'(AN), 32'hFF);
    cycle();
    check("guard1_an", 32'(AN), 32'hFF);
    cycle();
    check("bad_bcd_an", 32'(AN), 32'hFE);
    check("bad_bcd_seg", 32'(seg_obs), 32'h7F);

    minone_now = 4'd1;
    blink_mask = 8'h01;
    chk_int = 1;
    repeat (140) cycle();
    chk_int = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
